// File: rtl/park_pkg.sv
// Shared types and sizing for the parking-lot beam sensor decoder.
package park_pkg;

    localparam int unsigned COUNT_W          = 4;
    localparam int unsigned DEFAULT_CAPACITY = 15;

    typedef enum logic [2:0] {
        IDLE,
        EN_A,
        EN_AB,
        EN_B,
        EX_B,
        EX_AB,
        EX_A,
        WAIT_CLR
    } park_state_e;

endpackage

// File: rtl/sync2.sv
// Single-bit multi-flop synchronizer for an asynchronous sensor input.
module sync2 #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/park_sensor_decoder.sv
// Two-beam direction decoder: tracks entry/exit sequences and maintains a saturating
// occupancy count with error and overflow pulses.
module park_sensor_decoder
    import park_pkg::*;
#(
    parameter int unsigned CAPACITY    = DEFAULT_CAPACITY,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sensor_A,
    input  logic               sensor_B,
    output logic               inc,
    output logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               seq_err,
    output logic               ovf
);

    localparam logic [COUNT_W-1:0] CAP_L = COUNT_W'(CAPACITY);

    logic               w_a_s;
    logic               w_b_s;
    logic [1:0]         w_ab;
    park_state_e        r_state;
    park_state_e        w_state_nxt;
    logic               w_entry_done;
    logic               w_exit_done;
    logic               w_err;
    logic               w_ovf_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic [COUNT_W-1:0] r_count;
    logic               r_inc;
    logic               r_dec;
    logic               r_seq_err;
    logic               r_ovf;

    sync2 #(
        .STAGES (SYNC_STAGES)
    ) u_sync_a (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (sensor_A),
        .o_q     (w_a_s)
    );

    sync2 #(
        .STAGES (SYNC_STAGES)
    ) u_sync_b (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (sensor_B),
        .o_q     (w_b_s)
    );

    assign w_ab = {w_a_s, w_b_s};

    // Each tracking state owns one sensor pattern; seeing it again means "hold".
    always_comb begin
        w_state_nxt  = r_state;
        w_entry_done = 1'b0;
        w_exit_done  = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                case (w_ab)
                    2'b10:   w_state_nxt = EN_A;
                    2'b01:   w_state_nxt = EX_B;
                    2'b11:   w_err = 1'b1;
                    default: ;
                endcase
            end
            EN_A: begin
                case (w_ab)
                    2'b10:   ;
                    2'b11:   w_state_nxt = EN_AB;
                    2'b00:   w_state_nxt = IDLE;
                    default: w_err = 1'b1;
                endcase
            end
            EN_AB: begin
                case (w_ab)
                    2'b11:   ;
                    2'b01:   w_state_nxt = EN_B;
                    2'b10:   w_state_nxt = EN_A;
                    default: w_err = 1'b1;
                endcase
            end
            EN_B: begin
                case (w_ab)
                    2'b01:   ;
                    2'b00: begin
                        w_state_nxt  = IDLE;
                        w_entry_done = 1'b1;
                    end
                    2'b11:   w_state_nxt = EN_AB;
                    default: w_err = 1'b1;
                endcase
            end
            EX_B: begin
                case (w_ab)
                    2'b01:   ;
                    2'b11:   w_state_nxt = EX_AB;
                    2'b00:   w_state_nxt = IDLE;
                    default: w_err = 1'b1;
                endcase
            end
            EX_AB: begin
                case (w_ab)
                    2'b11:   ;
                    2'b10:   w_state_nxt = EX_A;
                    2'b01:   w_state_nxt = EX_B;
                    default: w_err = 1'b1;
                endcase
            end
            EX_A: begin
                case (w_ab)
                    2'b10:   ;
                    2'b00: begin
                        w_state_nxt = IDLE;
                        w_exit_done = 1'b1;
                    end
                    2'b11:   w_state_nxt = EX_AB;
                    default: w_err = 1'b1;
                endcase
            end
            WAIT_CLR: begin
                if (w_ab == 2'b00) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_err) begin
            w_state_nxt = WAIT_CLR;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        if (w_entry_done) begin
            if (r_count >= CAP_L) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end else if (w_exit_done) begin
            if (r_count == '0) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_seq_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_inc     <= w_entry_done;
            r_dec     <= w_exit_done;
            r_seq_err <= w_err;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign inc     = r_inc;
    assign dec     = r_dec;
    assign seq_err = r_seq_err;
    assign ovf     = r_ovf;
    assign count   = r_count;
    assign full    = (r_count == CAP_L);
    assign empty   = (r_count == '0);

endmodule

// File: tb/tb_park_sensor_decoder.sv
// Table-driven bench for park_sensor_decoder plus hand sequences for latency and mid-run reset.
module tb_park_sensor_decoder;

    logic       clk;
    logic       reset;
    logic       sensor_a;
    logic       sensor_b;
    logic       inc;
    logic       dec;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       seq_err;
    logic       ovf;

    int n_checks = 0;
    int n_errors = 0;

    int tot_inc  = 0;
    int tot_dec  = 0;
    int tot_err  = 0;
    int tot_ovf  = 0;
    int tot_both = 0;

    park_sensor_decoder #(
        .CAPACITY    (15),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sensor_A (sensor_a),
        .sensor_B (sensor_b),
        .inc      (inc),
        .dec      (dec),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .seq_err  (seq_err),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (inc)        tot_inc++;
        if (dec)        tot_dec++;
        if (seq_err)    tot_err++;
        if (ovf)        tot_ovf++;
        if (inc && dec) tot_both++;
    end

    // kind: 0 entry, 1 exit, 2 half entry + half exit, 3 00-11-00, 4 11 then exit-shaped walk
    typedef struct {
        int kind;
        int reps;
        bit rst;
        int e_inc;
        int e_dec;
        int e_err;
        int e_ovf;
        int e_cnt;
        bit e_full;
        bit e_empty;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] ab);
        @(negedge clk);
        {sensor_a, sensor_b} = ab;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        {sensor_a, sensor_b} = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic flush();
        repeat (6) step(2'b00);
    endtask

    task automatic run_kind(input int kind);
        case (kind)
            0: begin
                step(2'b00); step(2'b10); step(2'b11); step(2'b01); step(2'b00);
            end
            1: begin
                step(2'b00); step(2'b01); step(2'b11); step(2'b10); step(2'b00);
            end
            2: begin
                step(2'b10); step(2'b11); step(2'b10); step(2'b00);
                step(2'b01); step(2'b11); step(2'b01); step(2'b00);
            end
            3: begin
                step(2'b00); step(2'b11); step(2'b00);
            end
            default: begin
                step(2'b11); step(2'b01); step(2'b11); step(2'b10); step(2'b00);
            end
        endcase
    endtask

    initial begin
        int s_inc, s_dec, s_err, s_ovf;
        int lat;

        reset    = 1'b0;
        sensor_a = 1'b0;
        sensor_b = 1'b0;

        vecs[0] = '{0,  9, 1'b1, 9, 0, 0, 0,  9, 1'b0, 1'b0};
        vecs[1] = '{1,  3, 1'b0, 0, 3, 0, 0,  6, 1'b0, 1'b0};
        vecs[2] = '{2,  1, 1'b0, 0, 0, 0, 0,  6, 1'b0, 1'b0};
        vecs[3] = '{0, 14, 1'b1, 14, 0, 0, 0, 14, 1'b0, 1'b0};
        vecs[4] = '{0,  1, 1'b0, 1, 0, 0, 0, 15, 1'b1, 1'b0};
        vecs[5] = '{0,  3, 1'b0, 3, 0, 0, 3, 15, 1'b1, 1'b0};
        vecs[6] = '{3,  1, 1'b1, 0, 0, 1, 0,  0, 1'b0, 1'b1};
        vecs[7] = '{1,  1, 1'b0, 0, 1, 0, 1,  0, 1'b0, 1'b1};
        vecs[8] = '{4,  1, 1'b0, 0, 0, 1, 0,  0, 1'b0, 1'b1};

        // Reset state while reset is held low.
        repeat (2) @(negedge clk);
        chk("rst_count",   int'(count),   0);
        chk("rst_empty",   int'(empty),   1);
        chk("rst_full",    int'(full),    0);
        chk("rst_inc",     int'(inc),     0);
        chk("rst_dec",     int'(dec),     0);
        chk("rst_seq_err", int'(seq_err), 0);
        chk("rst_ovf",     int'(ovf),     0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            s_inc = tot_inc;
            s_dec = tot_dec;
            s_err = tot_err;
            s_ovf = tot_ovf;
            for (int r = 0; r < vecs[i].reps; r++) run_kind(vecs[i].kind);
            flush();
            chk($sformatf("v%0d_inc", i),   tot_inc - s_inc, vecs[i].e_inc);
            chk($sformatf("v%0d_dec", i),   tot_dec - s_dec, vecs[i].e_dec);
            chk($sformatf("v%0d_err", i),   tot_err - s_err, vecs[i].e_err);
            chk($sformatf("v%0d_ovf", i),   tot_ovf - s_ovf, vecs[i].e_ovf);
            chk($sformatf("v%0d_count", i), int'(count),     vecs[i].e_cnt);
            chk($sformatf("v%0d_full", i),  int'(full),      int'(vecs[i].e_full));
            chk($sformatf("v%0d_empty", i), int'(empty),     int'(vecs[i].e_empty));
        end

        // Latency: raw 00 applied before edge 0; inc must be seen after edge index SYNC_STAGES.
        do_reset();
        step(2'b10);
        step(2'b11);
        step(2'b01);
        step(2'b00);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (inc && lat < 0) lat = k;
        end
        chk("latency_edge", lat, 2);
        chk("latency_count", int'(count), 1);

        // Reset dropped while the FSM sits in EN_AB.
        run_kind(0);
        flush();
        chk("pre_rst_count", int'(count), 2);
        step(2'b10);
        step(2'b11);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s_inc = tot_inc;
        s_dec = tot_dec;
        step(2'b01);
        step(2'b00);
        flush();
        chk("mid_rst_no_inc", tot_inc - s_inc, 0);
        chk("mid_rst_no_dec", tot_dec - s_dec, 0);
        chk("mid_rst_count_after", int'(count), 0);

        chk("inc_dec_overlap", tot_both, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
